// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable bounds, variable step,
// synchronous load, wrap/saturate handling and overflow event reporting.
module updown_counter_param #(
  parameter int              WIDTH   = 32,
  parameter int              STEP_W  = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              ctrl,
  input  logic              sat_mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  output logic [WIDTH-1:0]  counter,
  output logic              at_max,
  output logic              at_min,
  output logic              wrap_pulse,
  output logic              limit_pulse,
  output logic              ovf_sticky,
  output logic              bound_err
);

  logic [WIDTH:0]   step_ext_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             over_s;
  logic             under_s;
  logic             hold_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic [WIDTH-1:0] nxt_count_s;
  logic             nxt_wrap_s;
  logic             nxt_limit_s;
  logic             nxt_ovf_s;

  // One extra bit keeps carry and borrow visible instead of silently wrapping.
  assign step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum_s      = {1'b0, counter} + step_ext_s;
  assign diff_s     = {1'b0, counter} - step_ext_s;
  assign over_s     = (sum_s > {1'b0, hi_bound});
  assign under_s    = diff_s[WIDTH] || (diff_s[WIDTH-1:0] < lo_bound);

  assign bound_err  = (lo_bound > hi_bound);
  assign at_max     = (counter == hi_bound);
  assign at_min     = (counter == lo_bound);
  assign hold_s     = ctrl || !en || (step == {STEP_W{1'b0}});

  // Load value clamp; inverted bounds make clamping meaningless, so pass it through.
  always_comb begin
    load_clamp_s = load_val;
    if (bound_err) begin
      load_clamp_s = load_val;
    end else if (load_val < lo_bound) begin
      load_clamp_s = lo_bound;
    end else if (load_val > hi_bound) begin
      load_clamp_s = hi_bound;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Next-state selection in priority order: load, bound error, hold, count.
  always_comb begin
    nxt_count_s = counter;
    nxt_wrap_s  = 1'b0;
    nxt_limit_s = 1'b0;
    nxt_ovf_s   = ovf_sticky;
    if (load) begin
      nxt_count_s = load_clamp_s;
      nxt_ovf_s   = 1'b0;
    end else if (bound_err || hold_s) begin
      nxt_count_s = counter;
    end else if (up) begin
      if (!over_s) begin
        nxt_count_s = sum_s[WIDTH-1:0];
      end else if (sat_mode) begin
        nxt_count_s = hi_bound;
        nxt_limit_s = 1'b1;
        nxt_ovf_s   = 1'b1;
      end else begin
        nxt_count_s = lo_bound;
        nxt_wrap_s  = 1'b1;
        nxt_ovf_s   = 1'b1;
      end
    end else begin
      if (!under_s) begin
        nxt_count_s = diff_s[WIDTH-1:0];
      end else if (sat_mode) begin
        nxt_count_s = lo_bound;
        nxt_limit_s = 1'b1;
        nxt_ovf_s   = 1'b1;
      end else begin
        nxt_count_s = hi_bound;
        nxt_wrap_s  = 1'b1;
        nxt_ovf_s   = 1'b1;
      end
    end
  end

  // State and event registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= RST_VAL;
      wrap_pulse  <= 1'b0;
      limit_pulse <= 1'b0;
      ovf_sticky  <= 1'b0;
    end else begin
      counter     <= nxt_count_s;
      wrap_pulse  <= nxt_wrap_s;
      limit_pulse <= nxt_limit_s;
      ovf_sticky  <= nxt_ovf_s;
    end
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the team's fixed 32-bit up/down counter with hold. It adds configurable width, runtime-programmable bounds, a variable step, synchronous load, and a wrap or saturate mode. It also provides terminal-count and wrap/limit event outputs. It serves as the general-purpose event/position counter for timer, address-generation and test-stimulus logic in the design.

Parameters:
WIDTH, 32, counter and bound width in bits (>= 2)
STEP_W, 8, width of the step input (<= WIDTH)
RST_VAL, 0, value loaded into count on reset (WIDTH bits)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
en  input  1  count enable; 0 = hold
up  input  1  direction: 1 = up, 0 = down
ctrl  input  1  hold request; 1 = hold count (same meaning as the existing counter's ctrl)
sat_mode  input  1  1 = saturate at bound, 0 = wrap to opposite bound
load  input  1  synchronous load request
load_val  input  WIDTH  value for load
step  input  STEP_W  increment/decrement magnitude, unsigned
lo_bound  input  WIDTH  lower count limit, unsigned, inclusive
hi_bound  input  WIDTH  upper count limit, unsigned, inclusive
counter  output  WIDTH  registered count value
at_max  output  1  counter == hi_bound (combinational from registered counter)
at_min  output  1  counter == lo_bound (combinational from registered counter)
wrap_pulse  output  1  registered; high for exactly 1 cycle after a wrap
limit_pulse  output  1  registered; high for exactly 1 cycle after a saturation clip
ovf_sticky  output  1  registered; set on any wrap or clip, cleared only by rst or load
bound_err  output  1  combinational; lo_bound > hi_bound

Behaviour:
- Reset (synchronous, active-high, checked every edge):
  - counter = RST_VAL; wrap_pulse = 0; limit_pulse = 0; ovf_sticky = 0.
  - Reset mid-count overrides all other inputs on that edge.
- Priority per rising edge: rst > load > bound_err > (ctrl=1 or en=0 or step=0) hold > count.
- Load:
  - counter = load_val clamped into [lo_bound, hi_bound]: below lo_bound -> lo_bound; above hi_bound -> hi_bound.
  - Clears ovf_sticky; pulses = 0.
  - Load while ctrl=1 still loads.
  - If bound_err=1, load_val is taken unclamped.
- bound_err=1 (no load): counter holds; pulses = 0.
- Hold (ctrl=1, en=0, or step=0): counter unchanged; pulses = 0; ovf_sticky unchanged.
- Count up:
  - sum = counter + zero-extended step, computed in WIDTH+1 bits so there is no silent modular wrap.
  - If sum <= hi_bound: counter = sum.
  - Else, sat_mode=1: counter = hi_bound, limit_pulse = 1.
  - Else, sat_mode=0: counter = lo_bound, wrap_pulse = 1.
- Count down:
  - diff = counter - step, computed in WIDTH+1 bits; borrow or diff < lo_bound means underflow.
  - No underflow: counter = diff.
  - Underflow, sat_mode=1: counter = lo_bound, limit_pulse = 1.
  - Underflow, sat_mode=0: counter = hi_bound, wrap_pulse = 1.
- Events:
  - Exactly at a bound and stepping further: a clip or wrap is counted; reaching a bound exactly is not an event.
  - Count already at hi_bound, up, sat_mode=1: counter stays, limit_pulse = 1 each such cycle.
  - Any wrap or clip sets ovf_sticky. wrap_pulse and limit_pulse are never high together.
- Counter outside bounds (after a bound change) while counting:
  - Up with counter > hi_bound: overflow rule applies.
  - Down with counter < lo_bound: underflow rule applies.
  - Holding does not modify an out-of-range counter.
- Latency: one cycle from inputs to counter and pulses. at_max, at_min and bound_err have zero latency relative to counter and bounds.
- Full range (lo_bound = 0, hi_bound = all ones, step = 1, wrap mode) reproduces the existing counter's wrap behaviour.

Test Plan:
- WIDTH=8, RST_VAL=8'h10, assert rst for 1 cycle mid-count -> next edge counter=8'h10, pulses 0, ovf_sticky 0.
- Bounds 0..255, step=1, up, sat_mode=0, load 8'hFE, count 3 cycles -> counter FF, 00 (wrap_pulse=1, ovf_sticky=1), 01; then down from 00 -> FF with wrap_pulse.
- Bounds 10..20, step=4, sat_mode=1, load 18, up -> 20 with limit_pulse=1, then again 20 with limit_pulse=1; down from 12 -> 10 with limit_pulse=1; at_min=1.
- Bounds 10..20, step=3, sat_mode=0, counter=19, up -> 10 with wrap_pulse; counter=11, down -> 20 with wrap_pulse.
- ctrl=1 or en=0 or step=0 for 5 cycles at counter=7 -> counter stays 7, pulses 0. Load 50 with bounds 10..20 and ctrl=1 -> counter=20, ovf_sticky cleared.
- lo_bound=30, hi_bound=20 -> bound_err=1, counter frozen while counting; restore bounds -> counting resumes next edge.
